seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Sequential restoring divider: the inverse of the counter/multiplier datapath.
//  Takes a 16-bit dividend (e.g. product q) and an 8-bit divisor (e.g. Q_2).
//  Returns quotient and remainder, one quotient bit per enabled clock.
//  Sits downstream of the multiplier and recovers Q_1 from q / Q_2 for self-check.
// PARAMETERS
//  WD  16  dividend and quotient width
//  WS  8   divisor and remainder width (WS <= WD)
// PORTS
//  CLK        in   1   system clock, rising edge
//  RESETN     in   1   asynchronous active-low reset
//  CE         in   1   clock enable; when 0, all state and outputs hold
//  IN_VALID   in   1   DIVIDEND/DIVISOR valid
//  IN_READY   out  1   block can accept an operation (1 only in IDLE)
//  DIVIDEND   in   WD  numerator, unsigned
//  DIVISOR    in   WS  denominator, unsigned
//  OUT_VALID  out  1   QUOT/REM/DIV0 valid (1 only in DONE)
//  OUT_READY  in   1   consumer accepts result
//  QUOT       out  WD  quotient, unsigned
//  REM        out  WS  remainder, unsigned
//  DIV0       out  1   the divide-by-zero flag for the current result
// BEHAVIOUR
//  Reset state: IDLE. IN_READY=1, OUT_VALID=0, QUOT=0, REM=0, DIV0=0, bit counter=0.
//  States: IDLE, CALC, DONE. A transition occurs only on CLK edges with CE=1.
//  IDLE: accept = IN_VALID & IN_READY & CE. On accept, latch operands.
//   - DIVISOR==0: go to DONE. Result: QUOT=all-ones, REM=DIVIDEND[WS-1:0], DIV0=1.
//   - otherwise: clear the partial remainder (WS+1 bits internally), set counter=WD-1, go to CALC.
//  CALC step, one per enabled edge, MSB first:
//   - r = {rem, dividend[cnt]}
//   - if r >= divisor: rem = r - divisor and qbit = 1; else rem = r and qbit = 0.
//   - After the step with cnt==0, go to DONE.
//  Latency: OUT_VALID rises exactly WD+1 enabled edges after accept (17 for default).
//   For a zero divisor it rises 1 enabled edge after accept.
//  DONE: OUT_VALID=1. QUOT/REM/DIV0 stay stable until OUT_READY & CE, then go to IDLE.
//   OUT_VALID falls on that same edge.
//  While not in IDLE, IN_READY=0. Operands at the inputs are ignored and DIVIDEND/DIVISOR may change freely.
//  No input accept and output handoff happen on the same edge; there is a minimum 1-cycle IDLE gap.
//  Arithmetic: the compare/subtract is WS+1 bits wide, with no overflow. Invariant: QUOT*DIVISOR+REM == DIVIDEND.
//  DIVIDEND < DIVISOR gives QUOT=0, REM=DIVIDEND. DIVIDEND==0 gives QUOT=0, REM=0 after the full WD steps.
//  CE=0 mid-CALC: the counter and partial results freeze, and computation resumes exactly where it stopped.
//  RESETN low in any state: immediately go to IDLE with all outputs at their reset values. The in-flight op is discarded.
//  QUOT/REM/DIV0 are registered outputs. They update only on the edge that enters DONE.
// STRUCTURE
//  Package div_pkg:
//   - state enum/localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
//   - default widths DIV_WD=16, DIV_WS=8
//   - counter width function clog2(WD)
//  Sub-module div_step: combinational single restoring step.
//   - Inputs: rem[WS-1:0], bit_in, divisor[WS-1:0].
//   - Outputs: rem_next[WS-1:0], qbit.
//  Top: FSM, operand/quotient shift registers, bit counter, and the handshake logic.
// TESTING
//  1 DIVIDEND=16'hFFFF, DIVISOR=8'hFF -> QUOT=257, REM=0, DIV0=0. OUT_VALID 17 edges after accept.
//  2 DIVIDEND=1000, DIVISOR=7 -> QUOT=142, REM=6.
//    DIVIDEND=5, DIVISOR=9 -> QUOT=0, REM=5.
//  3 DIVIDEND=16'h1234, DIVISOR=0 -> DIV0=1, QUOT=16'hFFFF, REM=8'h34. OUT_VALID 1 edge after accept.
//  4 Backpressure: hold OUT_READY=0 for 5 cycles in DONE -> outputs stable and IN_READY=0.
//    A new IN_VALID is ignored until 1 cycle after the handoff.
//  5 CE=0 for 4 cycles mid-CALC -> latency extends by exactly 4.
//    Pulse RESETN low mid-CALC -> IDLE, OUT_VALID=0, IN_READY=1 asynchronously.
//  6 System check: feed DIVIDEND=Q_1*Q_2, DIVISOR=Q_2 for all 8-bit pairs with Q_2!=0.
//    Required: QUOT=Q_1, REM=0. Any mismatch is a fail.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state codes,
// default operand widths and a counter-width helper.
package div_pkg;

  localparam int DIV_WD = 16;
  localparam int DIV_WS = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold the values 0 .. value-1, never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    if (bits < 1) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WS = DIV_WS
) (
  input  logic [WS-1:0] rem,
  input  logic          bit_in,
  input  logic [WS-1:0] divisor,
  output logic [WS-1:0] rem_next,
  output logic          qbit
);

  logic [WS:0] r;

  // The compare needs the extra top bit; the subtract can be done modulo
  // 2^WS because a successful result is always smaller than the divisor.
  always_comb begin
    r        = {rem, bit_in};
    qbit     = (r >= {1'b0, divisor});
    rem_next = qbit ? (r[WS-1:0] - divisor) : r[WS-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider producing one quotient bit per enabled clock,
// with valid/ready handshakes on both the operand and result sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WD = DIV_WD,
  parameter int WS = DIV_WS
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          CE,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [WD-1:0] DIVIDEND,
  input  logic [WS-1:0] DIVISOR,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [WD-1:0] QUOT,
  output logic [WS-1:0] REM,
  output logic          DIV0
);

  localparam int CW = clog2(WD);
  localparam logic [CW-1:0] CNT_LAST = CW'(WD - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WS-1:0] part_q, part_d;
  logic [WD-1:0] shift_q, shift_d;
  logic [WS-1:0] dvs_q, dvs_d;
  logic [WD-1:0] quot_q, quot_d;
  logic [WS-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;

  logic [WS-1:0] step_rem;
  logic          step_qbit;

  div_step #(.WS(WS)) u_step (
    .rem      (part_q),
    .bit_in   (shift_q[WD-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  // The shift register feeds dividend bits out of the top while quotient
  // bits enter at the bottom, so after WD steps it holds the quotient.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    shift_d = shift_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;

    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          shift_d = DIVIDEND;
          dvs_d   = DIVISOR;
          if (DIVISOR == '0) begin
            quot_d  = '1;
            rem_d   = DIVIDEND[WS-1:0];
            div0_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            part_d  = '0;
            cnt_d   = CNT_LAST;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        part_d  = step_rem;
        shift_d = {shift_q[WD-2:0], step_qbit};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quot_d  = {shift_q[WD-2:0], step_qbit};
          rem_d   = step_rem;
          div0_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CE gates every register, so a stalled divide resumes exactly where it left off.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      shift_q <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      shift_q <= shift_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign QUOT      = quot_q;
  assign REM       = rem_q;
  assign DIV0      = div0_q;

endmodule
